// File: rtl/escalonador_display_pkg.sv
// Shared types and constants for the OLED display link sequencer.
package escalonador_display_pkg;

    // Sequencer states, in the order they are normally visited.
    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_FETCH,
        ST_SEND
    } estado_t;

    // Frame source selector.
    typedef enum logic {
        SRC_IMG = 1'b0,
        SRC_BAR = 1'b1
    } fonte_t;

    // SSD1306 addressing commands and window limits.
    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
    localparam logic [7:0] COL_INI       = 8'h00;
    localparam logic [7:0] COL_FIM       = 8'h7F;
    localparam logic [7:0] PAG_IMG_INI   = 8'h00;
    localparam logic [7:0] PAG_IMG_FIM   = 8'h06;
    localparam logic [7:0] PAG_BAR       = 8'h07;
    localparam int unsigned N_ADDR       = 6;

    // Init command ROM, padded to a power of two so any address is in range.
    localparam int unsigned ROM_PROF = 32;
    localparam int unsigned ROM_AW   = 5;
    localparam logic [7:0] INIT_ROM [ROM_PROF] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
        8'hAF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Column/page window command sequence for the selected source.
    function automatic logic [7:0] addr_byte(input fonte_t src, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD_COL_ADDR;
            3'd1:    b = COL_INI;
            3'd2:    b = COL_FIM;
            3'd3:    b = CMD_PAGE_ADDR;
            3'd4:    b = (src == SRC_IMG) ? PAG_IMG_INI : PAG_BAR;
            3'd5:    b = (src == SRC_IMG) ? PAG_IMG_FIM : PAG_BAR;
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/escalonador_display_rom.sv
// Synchronous init command ROM for the SSD1306 panel, 1-cycle read latency.
module rom_init_ssd1306
    import escalonador_display_pkg::*;
#(
    parameter int unsigned N_INIT = 25
) (
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [7:0]        data
);

    localparam logic [ROM_AW-1:0] LIMITE = ROM_AW'(N_INIT);

    // Registered read; addresses beyond the list return zero.
    always_ff @(posedge clk) begin
        data <= (addr < LIMITE) ? INIT_ROM[addr] : '0;
    end

endmodule

// File: rtl/escalonador_display.sv
// OLED link sequencer: panel reset, init stream, then round-robin redraws
// of the image area and attribute bar towards the byte serializer.
module escalonador_display
    import escalonador_display_pkg::*;
#(
    parameter int unsigned RST_CICLOS = 1000,
    parameter int unsigned N_INIT     = 25,
    parameter int unsigned BYTES_IMG  = 896,
    parameter int unsigned BYTES_BAR  = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_img,
    input  logic       req_bar,
    input  logic [7:0] img_byte,
    input  logic [7:0] bar_byte,
    output logic [9:0] byte_counter,
    output logic [7:0] tx_data,
    output logic       tx_dc,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       io_reset,
    output logic       busy,
    output logic       gnt_img,
    output logic       gnt_bar,
    output logic       frame_done
);

    localparam int unsigned CW = $clog2(RST_CICLOS + 1);
    localparam logic [CW-1:0]     CICLOS_FIM = CW'(RST_CICLOS - 1);
    localparam logic [ROM_AW-1:0] INIT_FIM   = ROM_AW'(N_INIT - 1);
    localparam logic [2:0]        ADDR_FIM   = 3'(N_ADDR - 1);
    localparam logic [9:0]        ULT_IMG    = 10'(BYTES_IMG - 1);
    localparam logic [9:0]        ULT_BAR    = 10'(BYTES_BAR - 1);

    estado_t           estado, prox;
    logic [CW-1:0]     ciclos;
    logic              fim_ciclos;
    logic [ROM_AW-1:0] init_idx;
    logic              init_pronto;
    logic [7:0]        rom_data;
    logic [2:0]        addr_idx;
    logic [9:0]        contador;
    logic              pend_img, pend_bar;
    fonte_t            ultimo, fonte;
    logic              conceder_img, conceder_bar;
    logic              ultimo_byte;
    logic              aceito;
    logic              em_quadro;

    rom_init_ssd1306 #(
        .N_INIT(N_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (init_idx),
        .data (rom_data)
    );

    assign fim_ciclos   = (ciclos == CICLOS_FIM);
    assign ultimo_byte  = (fonte == SRC_IMG) ? (contador == ULT_IMG) : (contador == ULT_BAR);
    assign aceito       = tx_valid && tx_ready;
    assign em_quadro    = (estado == ST_ADDR) || (estado == ST_FETCH) || (estado == ST_SEND);
    assign busy         = (estado != ST_IDLE);
    assign gnt_img      = em_quadro && (fonte == SRC_IMG);
    assign gnt_bar      = em_quadro && (fonte == SRC_BAR);
    assign byte_counter = contador;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= ST_RST_LOW;
        else        estado <= prox;
    end

    // Next-state decode, grant arbitration and link outputs.
    always_comb begin
        prox         = estado;
        tx_valid     = 1'b0;
        tx_data      = '0;
        tx_dc        = 1'b0;
        io_reset     = 1'b1;
        conceder_img = 1'b0;
        conceder_bar = 1'b0;
        case (estado)
            ST_RST_LOW: begin
                io_reset = 1'b0;
                if (fim_ciclos) prox = ST_RST_WAIT;
            end
            ST_RST_WAIT: begin
                if (fim_ciclos) prox = ST_INIT;
            end
            ST_INIT: begin
                tx_valid = init_pronto;
                tx_data  = init_pronto ? rom_data : '0;
                if (init_pronto && tx_ready && (init_idx == INIT_FIM)) prox = ST_IDLE;
            end
            ST_IDLE: begin
                if (pend_img && pend_bar) begin
                    if (ultimo == SRC_IMG) conceder_bar = 1'b1;
                    else                   conceder_img = 1'b1;
                end else if (pend_img) begin
                    conceder_img = 1'b1;
                end else if (pend_bar) begin
                    conceder_bar = 1'b1;
                end
                if (pend_img || pend_bar) prox = ST_ADDR;
            end
            ST_ADDR: begin
                tx_valid = 1'b1;
                tx_data  = addr_byte(fonte, addr_idx);
                if (tx_ready && (addr_idx == ADDR_FIM)) prox = ST_FETCH;
            end
            ST_FETCH: begin
                prox = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_dc    = 1'b1;
                tx_data  = (fonte == SRC_IMG) ? img_byte : bar_byte;
                if (tx_ready) prox = ultimo_byte ? ST_IDLE : ST_FETCH;
            end
            default: prox = ST_RST_LOW;
        endcase
    end

    // Datapath: reset timer, ROM index, pending requests, byte counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ciclos      <= '0;
            init_idx    <= '0;
            init_pronto <= 1'b1;
            addr_idx    <= '0;
            contador    <= '0;
            pend_img    <= 1'b1;
            pend_bar    <= 1'b0;
            ultimo      <= SRC_BAR;
            fonte       <= SRC_IMG;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            pend_img   <= (pend_img && !conceder_img) || req_img;
            pend_bar   <= (pend_bar && !conceder_bar) || req_bar;

            if ((estado == ST_RST_LOW) || (estado == ST_RST_WAIT))
                ciclos <= fim_ciclos ? '0 : ciclos + 1'b1;
            else
                ciclos <= '0;

            // init_idx sits at 0 through reset, so rom[0] is already on the
            // ROM output on entry to INIT; later bytes need one fetch cycle.
            if (estado == ST_INIT) begin
                if (aceito) begin
                    init_idx    <= init_idx + 1'b1;
                    init_pronto <= 1'b0;
                end else begin
                    init_pronto <= 1'b1;
                end
            end

            if (conceder_img || conceder_bar) begin
                fonte    <= conceder_img ? SRC_IMG : SRC_BAR;
                ultimo   <= conceder_img ? SRC_IMG : SRC_BAR;
                addr_idx <= '0;
                contador <= '0;
            end

            if ((estado == ST_ADDR) && aceito)
                addr_idx <= addr_idx + 1'b1;

            if ((estado == ST_SEND) && aceito) begin
                if (ultimo_byte) begin
                    contador   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    contador <= contador + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_escalonador_display.sv
// Scoreboard bench for escalonador_display: expected link bytes are queued
// per frame; a negedge monitor checks every accepted byte and the handshake.
module tb_escalonador_display;

    localparam int RST_C  = 10;
    localparam int N_INI  = 25;
    localparam int B_IMG  = 896;
    localparam int B_BAR  = 128;

    logic       clk = 1'b0;
    logic       rst_n, req_img, req_bar, tx_ready;
    logic [7:0] img_byte, bar_byte;
    logic [9:0] byte_counter;
    logic [7:0] tx_data;
    logic       tx_dc, tx_valid, io_reset, busy, gnt_img, gnt_bar, frame_done;

    always #5 clk = ~clk;

    escalonador_display #(
        .RST_CICLOS(RST_C),
        .N_INIT    (N_INI),
        .BYTES_IMG (B_IMG),
        .BYTES_BAR (B_BAR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_img      (req_img),
        .req_bar      (req_bar),
        .img_byte     (img_byte),
        .bar_byte     (bar_byte),
        .byte_counter (byte_counter),
        .tx_data      (tx_data),
        .tx_dc        (tx_dc),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .io_reset     (io_reset),
        .busy         (busy),
        .gnt_img      (gnt_img),
        .gnt_bar      (gnt_bar),
        .frame_done   (frame_done)
    );

    // Frame sources: synchronous ROMs with random contents.
    logic [7:0] img_mem [B_IMG];
    logic [7:0] bar_mem [B_BAR];
    logic [7:0] golden_init [N_INI];

    always @(posedge clk) begin
        img_byte <= (int'(byte_counter) < B_IMG) ? img_mem[int'(byte_counter)] : 8'h00;
        bar_byte <= (int'(byte_counter) < B_BAR) ? bar_mem[int'(byte_counter)] : 8'h00;
    end

    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         src;   // 0 init, 1 image, 2 bar
        bit         last;
    } esp_t;

    esp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   fd_count = 0;
    int   exp_fd = 0;
    int   m_last = 2;
    bit   expect_fd = 0;
    bit   bp_en = 0;
    bit   hold_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_init();
        for (int i = 0; i < N_INI; i++)
            sb.push_back('{data: golden_init[i], dc: 1'b0, src: 0, last: 1'b0});
    endtask

    // One frame: column window 0..127, page window by source, then pixel data.
    task automatic push_frame(input int src);
        logic [7:0] cmd [6];
        int n;
        cmd[0] = 8'h21; cmd[1] = 8'd0; cmd[2] = 8'd127; cmd[3] = 8'h22;
        cmd[4] = (src == 1) ? 8'd0 : 8'd7;
        cmd[5] = (src == 1) ? 8'd6 : 8'd7;
        n = (src == 1) ? B_IMG : B_BAR;
        for (int i = 0; i < 6; i++)
            sb.push_back('{data: cmd[i], dc: 1'b0, src: src, last: 1'b0});
        for (int i = 0; i < n; i++)
            sb.push_back('{data: (src == 1) ? img_mem[i] : bar_mem[i], dc: 1'b1,
                           src: src, last: (i == n - 1)});
        exp_fd++;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy || expect_fd) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic pulse(input bit img, input bit bar);
        @(posedge clk); #1;
        req_img = img;
        req_bar = bar;
        @(posedge clk); #1;
        req_img = 1'b0;
        req_bar = 1'b0;
    endtask

    // Monitor: handshake stability, accepted-byte scoreboard, frame_done timing.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data;
    logic       prev_dc;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
                expect_fd = 1'b0;
            end else begin
                if (frame_done) fd_count++;
                if (expect_fd) begin
                    chk("frame_done_pulse", 32'(frame_done), 32'd1);
                    expect_fd = 1'b0;
                end else if (frame_done) begin
                    chk("frame_done_spurious", 32'(frame_done), 32'd0);
                end
                if (prev_hold) begin
                    chk("hold_valid", 32'(tx_valid), 32'd1);
                    chk("hold_data", 32'(tx_data), 32'(prev_data));
                    chk("hold_dc", 32'(tx_dc), 32'(prev_dc));
                end
                if (tx_valid && tx_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        esp_t e;
                        e = sb.pop_front();
                        chk("byte_data", 32'(tx_data), 32'(e.data));
                        chk("byte_dc", 32'(tx_dc), 32'(e.dc));
                        chk("byte_gnt_img", 32'(gnt_img), 32'(e.src == 1));
                        chk("byte_gnt_bar", 32'(gnt_bar), 32'(e.src == 2));
                        if (e.last) expect_fd = 1'b1;
                    end
                end
                prev_hold = tx_valid && !tx_ready;
                prev_data = tx_data;
                prev_dc   = tx_dc;
            end
        end
    end

    // Ready driver: random backpressure plus one forced 5-cycle stall at byte 100.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (hold_req && rst_n && tx_valid && tx_dc && byte_counter == 10'd100) begin
                logic [7:0] d;
                logic [9:0] c;
                tx_ready = 1'b0;
                d = tx_data;
                c = byte_counter;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("stall_valid", 32'(tx_valid), 32'd1);
                    chk("stall_data", 32'(tx_data), 32'(d));
                    chk("stall_counter", 32'(byte_counter), 32'(c));
                end
                hold_req = 1'b0;
                tx_ready = 1'b1;
            end else begin
                tx_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, highs, n;
        golden_init = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                        8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                        8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
        for (int i = 0; i < B_IMG; i++) img_mem[i] = 8'($urandom);
        for (int i = 0; i < B_BAR; i++) bar_mem[i] = 8'($urandom);
        rst_n = 1'b0;
        req_img = 1'b0;
        req_bar = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_io_reset", 32'(io_reset), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_dc", 32'(tx_dc), 32'd0);
        chk("rst_byte_counter", 32'(byte_counter), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_gnt", 32'({gnt_img, gnt_bar}), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        // Power-up: reset pulse timing, init list, forced image frame.
        push_init();
        push_frame(1);
        m_last = 1;
        rst_n = 1'b1;
        lows = 0;
        @(negedge clk);
        while (!io_reset && lows < 1000) begin lows++; @(negedge clk); end
        highs = 0;
        while (io_reset && !tx_valid && highs < 1000) begin highs++; @(negedge clk); end
        chk("io_reset_low_cycles", 32'(lows), 32'(RST_C));
        chk("io_reset_high_cycles", 32'(highs), 32'(RST_C));
        wait_idle("powerup", 20000);
        chk("powerup_frames", 32'(fd_count), 32'(exp_fd));
        chk("powerup_busy", 32'(busy), 32'd0);

        // Simultaneous requests after an image frame: bar first, then image.
        bp_en = 1'b1;
        hold_req = 1'b1;
        push_frame(2);
        push_frame(1);
        m_last = 1;
        pulse(1'b1, 1'b1);
        wait_idle("both", 20000);
        chk("both_frames", 32'(fd_count), 32'(exp_fd));
        chk("stall_seen", 32'(hold_req), 32'd0);

        // Repeated bar requests during a bar frame collapse to one extra frame.
        push_frame(2);
        push_frame(2);
        m_last = 2;
        pulse(1'b0, 1'b1);
        n = 0;
        while (!(gnt_bar && byte_counter >= 10'd10) && n < 5000) begin @(negedge clk); n++; end
        chk("bar_grant_seen", 32'(n < 5000), 32'd1);
        repeat (3) begin
            pulse(1'b0, 1'b1);
            repeat (6) @(posedge clk);
        end
        wait_idle("bar_repeat", 20000);
        chk("bar_repeat_frames", 32'(fd_count), 32'(exp_fd));

        // Random request patterns from IDLE, arbitrated round-robin.
        for (int k = 0; k < 3; k++) begin
            int r;
            r = $urandom_range(1, 3);
            if (r == 3) begin
                int first;
                first = (m_last == 1) ? 2 : 1;
                push_frame(first);
                push_frame(3 - first);
                m_last = 3 - first;
            end else begin
                push_frame(r);
                m_last = r;
            end
            pulse(r != 2, r != 1);
            wait_idle("random", 20000);
            chk("random_frames", 32'(fd_count), 32'(exp_fd));
        end

        // Reset in the middle of an image frame.
        push_frame(1);
        exp_fd--;
        pulse(1'b1, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(gnt_img && byte_counter == 10'd400) && n < 10000);
        chk("mid_reached_400", 32'(n < 10000), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_io_reset", 32'(io_reset), 32'd0);
        chk("mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_gnt_img", 32'(gnt_img), 32'd0);
        chk("mid_byte_counter", 32'(byte_counter), 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        push_init();
        push_frame(1);
        m_last = 1;
        rst_n = 1'b1;
        wait_idle("restart", 20000);
        chk("restart_frames", 32'(fd_count), 32'(exp_fd));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
